// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I front end.
package riscv_pkg;

    localparam int          RV_XLEN          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        instr;
        logic [RV_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with single-cycle flush; head is a registered read, visible whenever count > 0.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, credit-gated imem requests, in-order response tagging,
// instruction queue toward decode, and redirect flush with stale-response killing.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int               XLEN            = 32,
    parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(RESET_PC_DEFAULT),
    parameter int               QUEUE_DEPTH     = 2,
    parameter int               MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    localparam int LCNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [LCNT_W-1:0] live_q, live_d;
    logic [LCNT_W-1:0] kill_q, kill_d;
    logic              started_q, started_d;

    logic              req_fire, rsp_live, rsp_kill;
    logic              q_push, q_pop, q_empty, q_full;
    logic [QCNT_W-1:0] q_count;
    fetch_entry_t      q_head, q_in;
    logic              tag_push, tag_pop, tag_empty, tag_full;
    logic [LCNT_W-1:0] tag_count;
    logic [XLEN-1:0]   tag_head;
    logic              unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    // Issue only when every live request is guaranteed a queue slot and the memory has room.
    assign imem_req_valid = started_q && !redirect_valid
                            && ((32'(live_q) + 32'(q_count)) < 32'(QUEUE_DEPTH))
                            && ((32'(live_q) + 32'(kill_q)) < 32'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_kill = imem_rsp_valid && (kill_q != '0);
    assign rsp_live = imem_rsp_valid && (kill_q == '0) && !redirect_valid;

    always_comb begin
        pc_d      = pc_q;
        live_d    = live_q;
        kill_d    = kill_q;
        started_d = 1'b1;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving now is one of them.
            pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            live_d = '0;
            kill_d = kill_q + live_q - LCNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(4);
            case ({req_fire, rsp_live})
                2'b10:   live_d = live_q + LCNT_W'(1);
                2'b01:   live_d = live_q - LCNT_W'(1);
                default: live_d = live_q;
            endcase
            if (rsp_kill) kill_d = kill_q - LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            live_q    <= '0;
            kill_q    <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            live_q    <= live_d;
            kill_q    <= kill_d;
            started_q <= started_d;
        end
    end

    assign tag_push = req_fire;
    assign tag_pop  = rsp_live;

    fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (tag_push),
        .push_data (pc_q),
        .pop       (tag_pop),
        .head_data (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    assign q_in.instr = imem_rsp_data;
    assign q_in.pc    = tag_head;
    assign q_push     = rsp_live;
    assign q_pop      = id_valid && id_ready && !redirect_valid;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign id_valid    = !q_empty;
    assign id_instr    = q_empty ? NOP_INSTR : q_head.instr;
    assign id_pc       = q_empty ? '0 : q_head.pc;
    assign id_pc_plus4 = q_empty ? '0 : q_head.pc + XLEN'(4);

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((live_q != '0) || (kill_q != '0)));
    a_tag_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == live_q);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(tag_push && tag_full && !tag_pop));
    a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(tag_pop && tag_empty));
    a_queue_has_slot: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-built redirect/reset sequences,
// and randomized memory timing checked against a program-order PC model.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, id_valid, id_ready;
    logic [31:0] redirect_pc, id_instr, id_pc, id_pc_plus4;

    logic        req_valid5, req_ready5, rsp_valid5, redirect5, id_valid5, id_ready5;
    logic [31:0] req_addr5, rsp_data5, redirect_pc5, id_instr5, id_pc5, id_pc_plus4_5;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid5), .imem_req_ready(req_ready5), .imem_req_addr(req_addr5),
        .imem_rsp_valid(rsp_valid5), .imem_rsp_data(rsp_data5),
        .redirect_valid(redirect5), .redirect_pc(redirect_pc5),
        .id_valid(id_valid5), .id_ready(id_ready5), .id_instr(id_instr5),
        .id_pc(id_pc5), .id_pc_plus4(id_pc_plus4_5)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction memory content: unique word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h1234_5678, 2'b11};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    int    cyc = 0;
    int    last_due = -1000;
    int    lat_min = 1, lat_max = 1;
    int    pops = 0;

    logic [31:0] m_fetch_pc, m_id_pc;
    bit          expect_idle;

    logic        s_req_v, s_id_v;
    logic [31:0] s_addr, s_instr, s_pc, s_p4;

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        req_ready5 = 1'b0; rsp_valid5 = 1'b0; rsp_data5 = '0;
        redirect5 = 1'b0; redirect_pc5 = '0; id_ready5 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        pend.delete();
        last_due = -1000;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, NOP_INSTR);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_first_cycle_no_req", imem_req_valid, 1'b0);
        m_fetch_pc  = 32'h0;
        m_id_pc     = 32'h0;
        expect_idle = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    // One clock of the main DUT: drive, sample, check against the model, advance the model.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit idr, input bit rdy);
        int lat;
        int due;
        @(negedge clk);
        redirect_valid = redir; redirect_pc = rpc; id_ready = idr; imem_req_ready = rdy;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_req_v = imem_req_valid; s_addr = imem_req_addr;
        s_id_v = id_valid; s_instr = id_instr; s_pc = id_pc; s_p4 = id_pc_plus4;

        if (redir) check("req_blocked_by_redirect", s_req_v, 1'b0);
        if (s_req_v) check("fetch_addr", s_addr, m_fetch_pc);
        if (s_req_v && rdy)
            check("outstanding_limit", 32'((pend.size() + int'(imem_rsp_valid)) < MAXO), 32'd1);
        if (expect_idle) check("id_idle_after_redirect", s_id_v, 1'b0);
        if (s_id_v) begin
            check("id_pc", s_pc, m_id_pc);
            check("id_instr", s_instr, mem_word(m_id_pc));
            check("id_pc_plus4", s_p4, m_id_pc + 32'd4);
        end else begin
            check("id_nop_when_idle", s_instr, NOP_INSTR);
            check("id_pc_zero_when_idle", s_pc | s_p4, 32'h0);
        end

        if (redir) begin
            m_fetch_pc  = {rpc[31:2], 2'b00};
            m_id_pc     = {rpc[31:2], 2'b00};
            expect_idle = 1'b1;
        end else begin
            expect_idle = 1'b0;
            if (s_req_v && rdy) m_fetch_pc = m_fetch_pc + 32'd4;
            if (s_id_v && idr) begin
                m_id_pc = m_id_pc + 32'd4;
                pops++;
            end
        end
        if (s_req_v && rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{addr: s_addr, due: due});
            last_due = due;
        end
        @(posedge clk);
        cyc++;
    endtask

    typedef struct {
        logic        req_v;
        logic [31:0] addr;
        logic        id_v;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        bit          found;
        int          acc_at_redir;
        bit          p_v;
        logic [31:0] p_a;
        logic [31:0] acc5[$];
        logic [31:0] idpc5[$];
        logic [31:0] idp45[$];

        // Cycles 1..7 after reset, 1-cycle memory, always ready.
        tbl[0] = '{1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h4,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h0,  1'b1, 32'h0};
        tbl[3] = '{1'b1, 32'h8,  1'b1, 32'h4};
        tbl[4] = '{1'b1, 32'hC,  1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h0,  1'b1, 32'h8};
        tbl[6] = '{1'b1, 32'h10, 1'b1, 32'hC};

        rst_n = 1'b0;
        idle_inputs();

        // Test 1: steady stream.
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            check("t1_req_valid", s_req_v, tbl[i].req_v);
            if (tbl[i].req_v) check("t1_req_addr", s_addr, tbl[i].addr);
            check("t1_id_valid", s_id_v, tbl[i].id_v);
            if (tbl[i].id_v) begin
                check("t1_id_pc", s_pc, tbl[i].pc);
                check("t1_id_pc_plus4", s_p4, tbl[i].pc + 32'd4);
                check("t1_id_instr", s_instr, mem_word(tbl[i].pc));
            end
        end

        // Test 2: decode stalled for 10 cycles.
        do_reset();
        acc = 0;
        repeat (10) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (s_req_v) acc++;
        end
        check("t2_accepts_during_stall", acc, 2);
        check("t2_req_blocked_when_full", s_req_v, 1'b0);
        check("t2_head_held", s_id_v, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Test 3: redirect with two requests live.
        do_reset();
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("t3_no_req_while_killing", s_req_v, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            found = s_id_v;
        end
        check("t3_target_reached", found, 1'b1);
        if (found) check("t3_first_pc", s_pc, 32'h100);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Test 4: redirect coinciding with a response and a decode pop.
        do_reset();
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_pop_in_redirect_cycle", s_id_v, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("t4_queue_flushed", s_id_v, 1'b0);
        check("t4_req_after_redirect", s_req_v, 1'b1);
        check("t4_req_addr", s_addr, 32'h200);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("t4_target_delivered", s_id_v, 1'b1);
        check("t4_target_pc", s_pc, 32'h200);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Test 5: PC wrap from a high reset PC, then misaligned redirect target.
        do_reset();
        p_v = 1'b0; p_a = '0; acc_at_redir = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            redirect5 = (k == 8); redirect_pc5 = 32'h103;
            req_ready5 = 1'b1; id_ready5 = 1'b1;
            rsp_valid5 = p_v; rsp_data5 = mem_word(p_a);
            #1;
            if (k == 8) acc_at_redir = acc5.size();
            if (req_valid5) acc5.push_back(req_addr5);
            if (id_valid5) begin
                idpc5.push_back(id_pc5);
                idp45.push_back(id_pc_plus4_5);
            end
            p_v = req_valid5; p_a = req_addr5;
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        check("t5_accept_count", 32'(acc5.size() > acc_at_redir && acc_at_redir >= 3), 32'd1);
        if (acc5.size() > acc_at_redir && acc_at_redir >= 3) begin
            check("t5_fetch0", acc5[0], 32'hFFFF_FFF8);
            check("t5_fetch1", acc5[1], 32'hFFFF_FFFC);
            check("t5_fetch2", acc5[2], 32'h0000_0000);
            check("t5_redirect_aligned", acc5[acc_at_redir], 32'h0000_0100);
        end
        found = 1'b0;
        foreach (idpc5[i]) begin
            if (idpc5[i] == 32'hFFFF_FFFC && !found) begin
                found = 1'b1;
                check("t5_plus4_wraps", idp45[i], 32'h0);
            end
        end
        check("t5_wrap_entry_seen", found, 1'b1);

        // Test 6: reset with the queue full.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_queue_full_valid", s_id_v, 1'b1);
        check("t6_queue_full_no_req", s_req_v, 1'b0);
        do_reset();
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("t6_restart_req", s_req_v, 1'b1);
        check("t6_restart_addr", s_addr, 32'h0);

        // Randomized memory timing, back-pressure and redirects.
        lat_min = 1; lat_max = 4;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [31:0] tgt;
            r   = ($urandom_range(99, 0) < 4);
            tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                              : ($urandom & 32'h0000_0FFF);
            cycle(r, tgt, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7));
        end
        check("random_progress", 32'(pops > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
